mult_div_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit for the multicycle CPU datapath (MIPS mult/multu/div/divu).

---
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit for MIPS mult/multu/div/divu.
// Results land in HI/LO; div_zero pulses with done when the divisor is 0.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     ma_q, ma_d;
  logic [WIDTH-1:0]     mb_q, mb_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       msum;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [WIDTH:0]       rem_sh, diff;
  logic [2*WIDTH-1:0]   div_nxt;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  always_comb begin
    a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag = (sgn && b[WIDTH-1]) ? -b : b;

    // p holds {acc_hi, multiplier} for mult, {rem, dividend/quotient} for div
    msum    = {1'b0, p_q[2*WIDTH-1:WIDTH]}
            + (p_q[0] ? {1'b0, ma_q} : '0);
    mul_nxt = {msum, p_q[WIDTH-1:1]};

    rem_sh  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, mb_q};
    div_nxt = {diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0],
               p_q[WIDTH-2:0], ~diff[WIDTH]};

    prod = neg_q ? -p_q : p_q;
    quo  = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem  = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    p_d     = p_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          ma_d   = a_mag;
          mb_d   = b_mag;
          op_d   = op;
          neg_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d = sgn & a[WIDTH-1];
          p_d    = op ? {{WIDTH{1'b0}}, a_mag}
                      : {{WIDTH{1'b0}}, b_mag};
          if (op && b == '0) begin
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            cnt_d   = CW'(WIDTH);
            state_d = ITER;
          end
        end
      end
      ITER: begin
        p_d   = op_q ? div_nxt : mul_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (op_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      p_q     <= '0;
      op_q    <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      p_q     <= p_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == ITER) || (state_q == FIX);
  assign done     = (state_q == DONE);
  assign div_zero = (state_q == DONE) && dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: random and directed ops checked
// against a plain-arithmetic model of HI/LO.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .sgn      (sgn),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input bit mop, input bit msgn,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t   e;
    longint sx, sy, r;
    logic [63:0] u;
    e.dz = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!mop) begin
      if (msgn) u = 64'(sx * sy);
      else      u = {32'd0, x} * {32'd0, y};
      e.hi = u[63:32];
      e.lo = u[31:0];
    end else if (y == 32'd0) begin
      e.hi = m_hi;
      e.lo = m_lo;
      e.dz = 1'b1;
    end else if (msgn) begin
      r = sx / sy;
      e.lo = r[31:0];
      r = sx % sy;
      e.hi = r[31:0];
    end else begin
      e.lo = x / y;
      e.hi = x % y;
    end
    return e;
  endfunction

  task automatic issue(input bit iop, input bit isgn,
                       input logic [31:0] ia, input logic [31:0] ib);
    exp_t e;
    e = model(iop, isgn, ia, ib);
    m_hi = e.hi;
    m_lo = e.lo;
    sb.push_back(e);
    op    = iop;
    sgn   = isgn;
    a     = ia;
    b     = ib;
    start = 1'b1;
  endtask

  // Counts edges after the start edge until done, and busy cycles seen.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) nb++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string name, input bit iop, input bit isgn,
                        input logic [31:0] ia, input logic [31:0] ib);
    int n, nb;
    bit dzc;
    dzc = iop && (ib == 32'd0);
    @(negedge clk);
    issue(iop, isgn, ia, ib);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, nb);
    chk({name, " latency"}, 64'(n), dzc ? 64'd0 : 64'd33);
    chk({name, " busy cycles"}, 64'(nb), dzc ? 64'd0 : 64'd33);
    chk({name, " busy at done"}, 64'(busy), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("div_zero", 64'(div_zero), 64'(e.dz));
      end
    end
  end

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0000_0000;
      1:       v = 32'h0000_0001;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      5:       v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int n, nb, k;
    reset = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    sgn   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst div_zero", 64'(div_zero), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    reset = 1'b1;

    run_op("smul -3*7", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
    run_op("umul max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("smul -1*-1", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("sdiv -7/2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("sdiv min/-1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("udiv 7/2", 1'b1, 1'b0, 32'd7, 32'd2);
    run_op("div 5/0", 1'b1, 1'b0, 32'd5, 32'd0);

    // start re-pulsed mid-ITER with other operands is ignored
    @(negedge clk);
    issue(1'b0, 1'b0, 32'd1234, 32'd5678);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    a     = 32'd99;
    b     = 32'd77;
    op    = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, nb);
    chk("repulse latency", 64'(n + 6), 64'd33);

    // start in the DONE cycle chains a second op
    issue(1'b1, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFF0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, nb);
    chk("b2b latency", 64'(n), 64'd33);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             pick(), pick());
    end

    run_op("smul pre-rst", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
    // asynchronous reset at iteration 10, between edges
    @(negedge clk);
    issue(1'b0, 1'b0, 32'd3, 32'd5);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst done", 64'(done), 64'd0);
    chk("arst hi", 64'(hi), 64'd0);
    chk("arst lo", 64'(lo), 64'd0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || done !== 1'b0) k++;
    end
    chk("idle after rst", 64'(k), 64'd0);
    run_op("div 9/0 post-rst", 1'b1, 1'b1, 32'd9, 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
